if_fetch_unit: RTL and testbench

Instruction-fetch stage on the consuming side of the branch unit's PC-mux select. It owns the fetch PC and steers it with pc_mux_i: sequential, branch target or JAL target. It issues word fetches to instruction memory over a req/gnt/rvalid handshake and buffers responses in a small prefetch FIFO. Buffered instructions are presented to decode with a valid/ready handshake, and redirects flush all stale fetches.

---
 rtl/if_fetch_unit_if.sv | 23 ++
 rtl/if_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-fetch bus bundle: memory req/gnt/rvalid channel plus the decode valid/ready channel.
// master = fetch unit side, slave = memory/decode side.
interface if_fetch_unit_if;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    modport master (
        output instr_req_o, instr_addr_o, instr_valid_o, instr_o, pc_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_ready_i
    );

    modport slave (
        input  instr_req_o, instr_addr_o, instr_valid_o, instr_o, pc_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_ready_i
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding word fetches and buffers them in a prefetch FIFO.
// Optional macro FETCH_MISALIGN_CHECK_EN adds a registered fetch_misalign_o pulse for redirects to unaligned targets.
package riscv_cpu_pkg;
    localparam int BU_MUX_WIDTH = 2;
    localparam logic [BU_MUX_WIDTH-1:0] BU_PC_NEXT   = 2'd0;
    localparam logic [BU_MUX_WIDTH-1:0] BU_PC_BRANCH = 2'd1;
    localparam logic [BU_MUX_WIDTH-1:0] BU_PC_JAL    = 2'd2;
endpackage

module if_fetch_unit
    import riscv_cpu_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [BU_MUX_WIDTH-1:0] pc_mux_i,
    input  logic [31:0]             branch_target_i,
    input  logic [31:0]             jal_target_i,
    if_fetch_unit_if.master         bus
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                    fetch_misalign_o
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FLUSH
    } state_t;

    state_t            state_reg;
    logic [31:0]       fetch_pc_reg;
    logic [31:0]       txn_pc_reg;
    logic [31:0]       pc_mem   [FIFO_DEPTH];
    logic [31:0]       data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              redirect;
    logic [31:0]       target;
    logic [31:0]       target_aligned;
    logic              req;
    logic              grant;
    logic              push;
    logic              pop;
    logic              empty;

    // Encodings other than BRANCH/JAL fall through as sequential fetch.
    always_comb begin
        redirect = 1'b0;
        target   = fetch_pc_reg;
        case (pc_mux_i)
            BU_PC_BRANCH: begin
                redirect = 1'b1;
                target   = branch_target_i;
            end
            BU_PC_JAL: begin
                redirect = 1'b1;
                target   = jal_target_i;
            end
            default: begin
                redirect = 1'b0;
                target   = fetch_pc_reg;
            end
        endcase
    end

    assign target_aligned = target & 32'hFFFF_FFFC;

    // Only REQ can have a request up; outstanding is zero there, so the slot check reduces to count.
    assign empty = (count_reg == '0);
    assign req   = (state_reg == S_REQ) && (count_reg < DEPTH_C);
    assign grant = req && bus.instr_gnt_i;
    assign push  = (state_reg == S_WAIT) && bus.instr_rvalid_i && !redirect;
    assign pop   = !empty && bus.instr_ready_i && !redirect;

    assign bus.instr_req_o   = req;
    assign bus.instr_addr_o  = {fetch_pc_reg[31:2], 2'b00};
    assign bus.instr_valid_o = !empty;
    assign bus.instr_o       = empty ? 32'h0 : data_mem[rd_ptr_reg];
    assign bus.pc_o          = empty ? 32'h0 : pc_mem[rd_ptr_reg];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg    <= S_IDLE;
            fetch_pc_reg <= BOOT_ADDR;
            txn_pc_reg   <= 32'h0;
        end else begin
            case (state_reg)
                S_IDLE: state_reg <= S_REQ;
                S_REQ: begin
                    if (grant) begin
                        txn_pc_reg <= fetch_pc_reg;
                        state_reg  <= redirect ? S_FLUSH : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.instr_rvalid_i)
                        state_reg <= S_REQ;
                    else if (redirect)
                        state_reg <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (bus.instr_rvalid_i)
                        state_reg <= S_REQ;
                end
                default: state_reg <= S_IDLE;
            endcase

            if (redirect)
                fetch_pc_reg <= target_aligned;
            else if (grant)
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (redirect) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; empty masks the head outputs instead.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_reg]   <= txn_pc_reg;
            data_mem[wr_ptr_reg] <= bus.instr_rdata_i;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            misalign_reg <= 1'b0;
        else
            misalign_reg <= redirect && (target[1:0] != 2'b00);
    end

    assign fetch_misalign_o = misalign_reg;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory responder, decode sink and a scoreboard of expected {pc, instr}.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_if_fetch_unit;
    import riscv_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pc_mux;
    logic [31:0] br_t;
    logic [31:0] jal_t;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .BOOT_ADDR (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .pc_mux_i       (pc_mux),
        .branch_target_i(br_t),
        .jal_target_i   (jal_t),
        .bus            (bus)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misalign_o(misalign)
`endif
    );

    int          checks   = 0;
    int          failures = 0;
    int          pops     = 0;
    logic        rst_q;
    logic [1:0]  mux_q;
    logic [1:0]  mux_idle;
    logic [31:0] tgt_q;
    logic        ready_q;
    logic        gnt_en;
    logic        rv_block;
    logic        pending;
    logic        stale;
    logic [31:0] pend_addr;
    logic [63:0] exp_q[$];
    logic [31:0] grant_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_0F0F) + 32'h0001_0001;
    endfunction

    // One clock of stimulus: decode pop + scoreboard, memory response, grant, redirect bookkeeping.
    task automatic step();
        logic        redir;
        logic [63:0] e;
        @(negedge clk);
        rst_n              = rst_q;
        pc_mux             = mux_q;
        br_t               = tgt_q;
        jal_t              = tgt_q;
        bus.instr_ready_i  = ready_q;
        redir              = (mux_q == BU_PC_BRANCH) || (mux_q == BU_PC_JAL);
        mux_q              = mux_idle;
        bus.instr_gnt_i    = 1'b0;
        bus.instr_rvalid_i = 1'b0;
        if (!rst_q) begin
            pending = 1'b0;
            stale   = 1'b0;
            exp_q.delete();
            return;
        end
        if (bus.instr_valid_o && ready_q && !redir) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_unexpected got pc=%08h instr=%08h required=nothing", bus.pc_o, bus.instr_o);
            end else begin
                e = exp_q.pop_front();
                if ({bus.pc_o, bus.instr_o} !== e) begin
                    failures++;
                    $display("FAIL scoreboard_data got pc=%08h instr=%08h required pc=%08h instr=%08h",
                             bus.pc_o, bus.instr_o, e[63:32], e[31:0]);
                end
                $display("txn deliver pc=%08h instr=%08h", bus.pc_o, bus.instr_o);
            end
            pops++;
        end
        if (pending && !rv_block) begin
            bus.instr_rvalid_i = 1'b1;
            bus.instr_rdata_i  = mem_word(pend_addr);
            if (!stale && !redir)
                exp_q.push_back({pend_addr, mem_word(pend_addr)});
            pending = 1'b0;
            stale   = 1'b0;
        end
        if (bus.instr_req_o && gnt_en) begin
            bus.instr_gnt_i = 1'b1;
            pending         = 1'b1;
            pend_addr       = bus.instr_addr_o;
            grant_q.push_back(bus.instr_addr_o);
            $display("txn grant addr=%08h", bus.instr_addr_o);
        end
        if (redir) begin
            exp_q.delete();
            if (pending)
                stale = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_q    = 1'b0;
        mux_q    = BU_PC_NEXT;
        mux_idle = BU_PC_NEXT;
        ready_q  = 1'b0;
        gnt_en   = 1'b0;
        rv_block = 1'b0;
        repeat (3) step();
        rst_q = 1'b1;
        step();
        grant_q.delete();
        pops = 0;
    endtask

    task automatic test_reset();
        rst_q    = 1'b0;
        mux_q    = BU_PC_NEXT;
        mux_idle = BU_PC_NEXT;
        ready_q  = 1'b0;
        gnt_en   = 1'b0;
        rv_block = 1'b0;
        repeat (3) step();
        checks++;
        if ({bus.instr_req_o, bus.instr_valid_o, bus.instr_addr_o, bus.instr_o, bus.pc_o} !== {2'b00, 96'h0}) begin
            failures++;
            $display("FAIL reset_values got req=%b valid=%b addr=%08h instr=%08h pc=%08h required all zero",
                     bus.instr_req_o, bus.instr_valid_o, bus.instr_addr_o, bus.instr_o, bus.pc_o);
        end
        rst_q = 1'b1;
        step();
        checks++;
        if (bus.instr_req_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req got req=%b required 0", bus.instr_req_o);
        end
        step();
        checks++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL first_req got req=%b addr=%08h required req=1 addr=00000000", bus.instr_req_o, bus.instr_addr_o);
        end
        step();
        checks++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL addr_hold got req=%b addr=%08h required req=1 addr=00000000", bus.instr_req_o, bus.instr_addr_o);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        ready_q  = 1'b1;
        gnt_en   = 1'b1;
        mux_q    = 2'd3;
        mux_idle = 2'd3;
        tgt_q    = 32'h0000_0500;
        for (int i = 0; i < 30; i++) begin
            step();
            if (grant_q.size() >= 3) break;
        end
        mux_idle = BU_PC_NEXT;
        checks++;
        if (grant_q.size() < 3) begin
            failures++;
            $display("FAIL seq_timeout got grants=%0d required 3", grant_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (grant_q[i] !== 32'(4 * i)) begin
                    failures++;
                    $display("FAIL seq_addr%0d got %08h required %08h", i, grant_q[i], 32'(4 * i));
                end
            end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (pops >= 3) break;
        end
        checks++;
        if (pops < 3) begin
            failures++;
            $display("FAIL seq_deliver got pops=%0d required 3", pops);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready_q = 1'b0;
        gnt_en  = 1'b1;
        repeat (12) step();
        checks++;
        if (grant_q.size() != 2 || bus.instr_req_o !== 1'b0 || bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h0) begin
            failures++;
            $display("FAIL full_stall got grants=%0d req=%b valid=%b pc=%08h required grants=2 req=0 valid=1 pc=00000000",
                     grant_q.size(), bus.instr_req_o, bus.instr_valid_o, bus.pc_o);
        end
        ready_q = 1'b1;
        step();
        ready_q = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (grant_q.size() >= 3) break;
        end
        checks++;
        if (grant_q.size() < 3 || grant_q[2] !== 32'h8) begin
            failures++;
            $display("FAIL resume_addr got grants=%0d last=%08h required grant at 00000008",
                     grant_q.size(), grant_q.size() > 0 ? grant_q[$] : 32'h0);
        end
    endtask

    task automatic test_branch_flush();
        logic found;
        do_reset();
        ready_q = 1'b1;
        gnt_en  = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (grant_q.size() > 0 && grant_q[$] == 32'hC) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL flush_reach_c got grants=%0d required grant at 0000000c", grant_q.size());
        end
        rv_block = 1'b1;
        mux_q    = BU_PC_BRANCH;
        tgt_q    = 32'h0000_0100;
        step();
        grant_q.delete();
        step();
        checks++;
        if (bus.instr_valid_o !== 1'b0 || bus.instr_req_o !== 1'b0 || bus.instr_addr_o !== 32'h100) begin
            failures++;
            $display("FAIL flush_state got valid=%b req=%b addr=%08h required valid=0 req=0 addr=00000100",
                     bus.instr_valid_o, bus.instr_req_o, bus.instr_addr_o);
        end
        rv_block = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (grant_q.size() > 0) break;
        end
        checks++;
        if (grant_q.size() == 0 || grant_q[0] !== 32'h100) begin
            failures++;
            $display("FAIL flush_new_addr got grants=%0d first=%08h required 00000100",
                     grant_q.size(), grant_q.size() > 0 ? grant_q[0] : 32'h0);
        end
        repeat (8) step();
    endtask

    task automatic test_jal_rvalid();
        do_reset();
        ready_q = 1'b1;
        gnt_en  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (grant_q.size() > 0) break;
        end
        mux_q = BU_PC_JAL;
        tgt_q = 32'h0000_0040;
        step();
        step();
        checks++;
        if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h40 || bus.instr_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL jal_redirect got req=%b addr=%08h valid=%b required req=1 addr=00000040 valid=0",
                     bus.instr_req_o, bus.instr_addr_o, bus.instr_valid_o);
        end
        repeat (8) step();
    endtask

    task automatic test_wrap();
        do_reset();
        ready_q = 1'b1;
        gnt_en  = 1'b1;
        mux_q   = BU_PC_BRANCH;
        tgt_q   = 32'hFFFF_FFFC;
        for (int i = 0; i < 20; i++) begin
            step();
            if (grant_q.size() >= 3) break;
        end
        checks++;
        if (grant_q.size() < 3 || grant_q[1] !== 32'hFFFF_FFFC || grant_q[2] !== 32'h0) begin
            failures++;
            $display("FAIL pc_wrap got grants=%0d g1=%08h g2=%08h required g1=fffffffc g2=00000000",
                     grant_q.size(), grant_q.size() > 1 ? grant_q[1] : 32'h0, grant_q.size() > 2 ? grant_q[2] : 32'h0);
        end
        repeat (6) step();
    endtask

    task automatic test_misalign();
        do_reset();
        ready_q = 1'b1;
        gnt_en  = 1'b0;
        mux_q   = BU_PC_JAL;
        tgt_q   = 32'h0000_0102;
        step();
        step();
        checks++;
        if (bus.instr_addr_o !== 32'h100 || bus.instr_req_o !== 1'b1) begin
            failures++;
            $display("FAIL misalign_addr got addr=%08h req=%b required addr=00000100 req=1", bus.instr_addr_o, bus.instr_req_o);
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        checks++;
        if (misalign !== 1'b1) begin
            failures++;
            $display("FAIL misalign_pulse got %b required 1", misalign);
        end
        step();
        checks++;
        if (misalign !== 1'b0) begin
            failures++;
            $display("FAIL misalign_clear got %b required 0", misalign);
        end
`endif
    endtask

    initial begin
        rst_n              = 1'b0;
        pc_mux             = BU_PC_NEXT;
        br_t               = 32'h0;
        jal_t              = 32'h0;
        bus.instr_gnt_i    = 1'b0;
        bus.instr_rvalid_i = 1'b0;
        bus.instr_rdata_i  = 32'h0;
        bus.instr_ready_i  = 1'b0;
        tgt_q              = 32'h0;
        pending            = 1'b0;
        stale              = 1'b0;
        pend_addr          = 32'h0;

        test_reset();
        test_sequential();
        test_backpressure();
        test_branch_flush();
        test_jal_rvalid();
        test_wrap();
        test_misalign();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
